// File: rtl/up_dn_sweep_ctrl.sv
// Sweeps an external 5-bit up/down counter between latched Top/Bottom limits for a set number of round trips.
// Strobes are gated by a prescaler tick; Abort drops all strobes in the cycle it is seen.
module up_dn_sweep_ctrl #(
    parameter int PRESCALE = 1,
    parameter int CYC_W    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Abort,
    input  logic [4:0]       Start_Val,
    input  logic [4:0]       Top,
    input  logic [4:0]       Bottom,
    input  logic [CYC_W-1:0] Cycles,
    input  logic [4:0]       Counter,
    input  logic             High,
    input  logic             Low,
    output logic [4:0]       IN,
    output logic             Load,
    output logic             Up,
    output logic             Down,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [CYC_W-1:0] Trips
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);

    state_t           state_q;
    logic [4:0]       sv_q;
    logic [4:0]       top_q;
    logic [4:0]       bot_q;
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] trips_q;
    logic [CYC_W-1:0] trips_d;
    logic [7:0]       presc_q;
    logic [7:0]       presc_d;
    logic             err_q;
    logic             sweeping;
    logic             tick;

    assign sweeping = (state_q == S_UP) || (state_q == S_DOWN);
    assign tick     = sweeping && (presc_q == PS_MAX);
    assign presc_d  = (presc_q == PS_MAX) ? 8'd0 : presc_q + 8'd1;
    assign trips_d  = trips_q + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            sv_q    <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            cyc_q   <= '0;
            trips_q <= '0;
            presc_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start && !Abort) begin
                        if (Bottom <= Top) begin
                            sv_q    <= Start_Val;
                            top_q   <= Top;
                            bot_q   <= Bottom;
                            cyc_q   <= Cycles;
                            trips_q <= '0;
                            err_q   <= 1'b0;
                            state_q <= S_LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    presc_q <= '0;
                    state_q <= Abort ? S_IDLE : S_UP;
                end
                S_UP: begin
                    if (Abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        presc_q <= presc_d;
                        if (Counter >= top_q)
                            state_q <= S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (Abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        presc_q <= presc_d;
                        if (Counter <= bot_q) begin
                            trips_q <= trips_d;
                            // Cycles of zero never matches, so the sweep runs until aborted
                            state_q <= ((cyc_q != '0) && (trips_d == cyc_q)) ? S_DONE : S_UP;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign IN    = sv_q;
    assign Load  = (state_q == S_LOAD) && !Abort;
    assign Up    = (state_q == S_UP) && tick && (Counter < top_q) && !High && !Abort;
    assign Down  = (state_q == S_DOWN) && tick && (Counter > bot_q) && !Low && !Abort;
    assign Busy  = (state_q == S_LOAD) || sweeping;
    assign Done  = (state_q == S_DONE);
    assign Err   = err_q;
    assign Trips = trips_q;

endmodule

// File: tb/tb_up_dn_sweep_ctrl.sv
// Directed bench: two controllers (PRESCALE 1 and 3), each driving a behavioural 5-bit counter.
module tb_up_dn_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic [4:0] sv = '0;
    logic [4:0] top = '0;
    logic [4:0] bot = '0;
    logic [3:0] cyc = '0;

    logic [4:0] in1, in3;
    logic       load1, up1, dn1, busy1, done1, err1;
    logic       load3, up3, dn3, busy3, done3, err3;
    logic [3:0] trips1, trips3;
    logic [4:0] cnt1 = '0;
    logic [4:0] cnt3 = '0;
    logic       viol1 = 1'b0;
    logic       viol3 = 1'b0;
    logic       high1, low1, high3, low3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign high1 = (cnt1 == 5'd31);
    assign low1  = (cnt1 == 5'd0);
    assign high3 = (cnt3 == 5'd31);
    assign low3  = (cnt3 == 5'd0);

    up_dn_sweep_ctrl #(.PRESCALE(1), .CYC_W(4)) dut1 (
        .CLK(clk), .RST(rst_n), .Start(start1), .Abort(abort),
        .Start_Val(sv), .Top(top), .Bottom(bot), .Cycles(cyc),
        .Counter(cnt1), .High(high1), .Low(low1),
        .IN(in1), .Load(load1), .Up(up1), .Down(dn1),
        .Busy(busy1), .Done(done1), .Err(err1), .Trips(trips1)
    );

    up_dn_sweep_ctrl #(.PRESCALE(3), .CYC_W(4)) dut3 (
        .CLK(clk), .RST(rst_n), .Start(start3), .Abort(abort),
        .Start_Val(sv), .Top(top), .Bottom(bot), .Cycles(cyc),
        .Counter(cnt3), .High(high3), .Low(low3),
        .IN(in3), .Load(load3), .Up(up3), .Down(dn3),
        .Busy(busy3), .Done(done3), .Err(err3), .Trips(trips3)
    );

    // Behavioural counters; illegal strobe combinations latch a violation flag
    always @(posedge clk) begin
        if (load1) cnt1 <= in1;
        else if (up1) cnt1 <= cnt1 + 5'd1;
        else if (dn1) cnt1 <= cnt1 - 5'd1;
        if ((up1 && (dn1 || load1)) || (dn1 && load1) || (up1 && high1) || (dn1 && low1))
            viol1 <= 1'b1;
        if (load3) cnt3 <= in3;
        else if (up3) cnt3 <= cnt3 + 5'd1;
        else if (dn3) cnt3 <= cnt3 - 5'd1;
        if ((up3 && (dn3 || load3)) || (dn3 && load3) || (up3 && high3) || (dn3 && low3))
            viol3 <= 1'b1;
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({in1, load1, up1, dn1, busy1, done1, err1, trips1} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outs1 got %h exp 0000", {in1, load1, up1, dn1, busy1, done1, err1, trips1});
        end
        checks++;
        if ({in3, load3, up3, dn3, busy3, done3, err3, trips3} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outs3 got %h exp 0000", {in3, load3, up3, dn3, busy3, done3, err3, trips3});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b exp 0", busy1); end
    endtask

    task automatic test_sweep();
        logic [4:0] exp_s [16] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd5, 5'd4, 5'd3, 5'd2,
                                   5'd2, 5'd3, 5'd4, 5'd5, 5'd5, 5'd4, 5'd3, 5'd2};
        @(negedge clk);
        sv = 5'd2; top = 5'd5; bot = 5'd2; cyc = 4'd2; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; sv = 5'd17; top = 5'd0; bot = 5'd31; cyc = 4'd0;
        checks++;
        if ({load1, busy1, in1} !== {1'b1, 1'b1, 5'd2}) begin
            errors++; $display("FAIL sweep_load got %b exp 1100010", {load1, busy1, in1});
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (cnt1 !== exp_s[i]) begin
                errors++; $display("FAIL sweep_cnt[%0d] got %0d exp %0d", i, cnt1, exp_s[i]);
            end
            checks++;
            if ({done1, busy1} !== 2'b01) begin
                errors++; $display("FAIL sweep_busy[%0d] got %b exp 01", i, {done1, busy1});
            end
            if (i == 8) begin
                checks++;
                if (trips1 !== 4'd1) begin errors++; $display("FAIL sweep_trips1 got %0d exp 1", trips1); end
            end
        end
        @(negedge clk);
        checks++;
        if ({done1, busy1, trips1} !== {1'b1, 1'b0, 4'd2}) begin
            errors++; $display("FAIL sweep_done got %b exp 100010", {done1, busy1, trips1});
        end
        @(negedge clk);
        checks++;
        if ({done1, trips1, viol1} !== {1'b0, 4'd2, 1'b0}) begin
            errors++; $display("FAIL sweep_after got %b exp 000100", {done1, trips1, viol1});
        end
    endtask

    task automatic test_prescale();
        logic [4:0] exp_p [13] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd2,
                                   5'd2, 5'd2, 5'd1, 5'd1, 5'd1, 5'd0};
        logic eu, ed;
        @(negedge clk);
        sv = 5'd0; top = 5'd2; bot = 5'd0; cyc = 4'd1; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        checks++;
        if (load3 !== 1'b1) begin errors++; $display("FAIL pre_load got %b exp 1", load3); end
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            eu = (i == 3) || (i == 6);
            ed = (i == 9) || (i == 12);
            checks++;
            if ({up3, dn3} !== {eu, ed}) begin
                errors++; $display("FAIL pre_strobe[%0d] got %b exp %b", i, {up3, dn3}, {eu, ed});
            end
            checks++;
            if (cnt3 !== exp_p[i-1]) begin
                errors++; $display("FAIL pre_cnt[%0d] got %0d exp %0d", i, cnt3, exp_p[i-1]);
            end
        end
        @(negedge clk);
        checks++;
        if ({done3, busy3, trips3, viol3} !== {1'b1, 1'b0, 4'd1, 1'b0}) begin
            errors++; $display("FAIL pre_done got %b exp 1000010", {done3, busy3, trips3, viol3});
        end
    endtask

    task automatic test_err_and_equal_limits();
        @(negedge clk);
        sv = 5'd7; top = 5'd4; bot = 5'd9; cyc = 4'd1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if ({err1, busy1, load1} !== 3'b100) begin
            errors++; $display("FAIL err_set got %b exp 100", {err1, busy1, load1});
        end
        @(negedge clk);
        checks++;
        if ({err1, busy1} !== 2'b10) begin errors++; $display("FAIL err_sticky got %b exp 10", {err1, busy1}); end
        sv = 5'd4; top = 5'd4; bot = 5'd4; cyc = 4'd1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if ({err1, load1, in1} !== {1'b0, 1'b1, 5'd4}) begin
            errors++; $display("FAIL err_clear got %b exp 0100100", {err1, load1, in1});
        end
        @(negedge clk);
        checks++;
        if ({up1, dn1, busy1, trips1} !== {3'b001, 4'd0}) begin
            errors++; $display("FAIL eq_up got %b exp 0010000", {up1, dn1, busy1, trips1});
        end
        @(negedge clk);
        checks++;
        if ({up1, dn1, busy1} !== 3'b001) begin errors++; $display("FAIL eq_down got %b exp 001", {up1, dn1, busy1}); end
        @(negedge clk);
        checks++;
        if ({done1, trips1} !== {1'b1, 4'd1}) begin
            errors++; $display("FAIL eq_done got %b exp 10001", {done1, trips1});
        end
    endtask

    task automatic test_abort_full_range();
        int n = 0;
        int first = 0;
        @(negedge clk);
        sv = 5'd30; top = 5'd31; bot = 5'd0; cyc = 4'd0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (trips1 != 4'd3 && n < 400) begin
            @(negedge clk);
            n++;
            if (trips1 == 4'd1 && first == 0) first = n;
        end
        checks++;
        if (n !== 163) begin errors++; $display("FAIL full_trip3_cycle got %0d exp 163", n); end
        checks++;
        if (first !== 35) begin errors++; $display("FAIL full_trip1_cycle got %0d exp 35", first); end
        checks++;
        if (viol1 !== 1'b0) begin errors++; $display("FAIL full_no_wrap got %b exp 0", viol1); end
        abort = 1'b1;
        #1;
        checks++;
        if ({up1, dn1, load1, busy1} !== 4'b0001) begin
            errors++; $display("FAIL abort_strobes got %b exp 0001", {up1, dn1, load1, busy1});
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy1, done1, trips1, cnt1} !== {2'b00, 4'd3, 5'd0}) begin
            errors++; $display("FAIL abort_idle got %b exp 00001100000", {busy1, done1, trips1, cnt1});
        end
        @(negedge clk);
        checks++;
        if ({done1, busy1} !== 2'b00) begin errors++; $display("FAIL abort_no_done got %b exp 00", {done1, busy1}); end
    endtask

    task automatic test_start_while_busy();
        @(negedge clk);
        sv = 5'd0; top = 5'd3; bot = 5'd0; cyc = 4'd1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        sv = 5'd9; top = 5'd20; cyc = 4'd3; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if ({busy1, in1} !== {1'b1, 5'd0}) begin errors++; $display("FAIL busy_start_ignored got %b exp 100000", {busy1, in1}); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done1, trips1, in1, cnt1} !== {1'b1, 4'd1, 5'd0, 5'd0}) begin
            errors++; $display("FAIL busy_done got %b exp 10001_0_0", {done1, trips1, in1, cnt1});
        end
        @(negedge clk);
        sv = 5'd3; top = 5'd10; bot = 5'd1; cyc = 4'd1; start1 = 1'b1; abort = 1'b1;
        @(negedge clk);
        start1 = 1'b0; abort = 1'b0;
        checks++;
        if ({busy1, load1} !== 2'b00) begin errors++; $display("FAIL start_abort_idle got %b exp 00", {busy1, load1}); end
        @(negedge clk);
        checks++;
        if ({busy1, load1, in1} !== {2'b00, 5'd0}) begin
            errors++; $display("FAIL start_abort_hold got %b exp 0000000", {busy1, load1, in1});
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        sv = 5'd5; top = 5'd31; bot = 5'd0; cyc = 4'd0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({up1, busy1} !== 2'b11) begin errors++; $display("FAIL mid_up got %b exp 11", {up1, busy1}); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in1, load1, up1, dn1, busy1, done1, err1, trips1} !== 16'h0) begin
            errors++; $display("FAIL mid_reset_outs got %h exp 0000", {in1, load1, up1, dn1, busy1, done1, err1, trips1});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy1, up1} !== 2'b00) begin errors++; $display("FAIL mid_reset_hold[%0d] got %b exp 00", i, {busy1, up1}); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy1, load1, trips1} !== 6'b0) begin
            errors++; $display("FAIL mid_after_release got %b exp 000000", {busy1, load1, trips1});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sweep();
        test_prescale();
        test_err_and_equal_limits();
        test_abort_full_range();
        test_start_while_busy();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_dn_sweep_ctrl.md
Name: up_dn_sweep_ctrl

Overview:
- Sequencer for the shared 5-bit up/down counter: loads a start value, then drives Up/Down to sweep the count between programmable Top and Bottom limits for a programmed number of round trips.
- Sits beside the counter. Drives its IN/Load/Up/Down inputs and observes its Counter/High/Low outputs.
- A prescaler sets the step rate, and software-style Start/Abort/Done/Busy handshakes control each run.

Parameters:
- PRESCALE, 1: clock cycles per counter step (1 = step every cycle); legal range 1..255.
- CYC_W, 4: width of the round-trip count.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous assert, active-low; clears all state and outputs
- Start  in  1  one-cycle request; latches config and begins a run (ignored unless IDLE)
- Abort  in  1  terminates any run, returns to IDLE
- Start_Val  in  5  value loaded into counter at run start
- Top  in  5  upper sweep limit
- Bottom  in  5  lower sweep limit
- Cycles  in  CYC_W  number of up+down round trips; 0 = run until Abort
- Counter  in  5  counter value fed back from counter
- High  in  1  counter at 31
- Low  in  1  counter at 0
- IN  out  5  load value to counter (registered Start_Val copy)
- Load  out  1  counter load strobe
- Up  out  1  counter increment strobe
- Down  out  1  counter decrement strobe
- Busy  out  1  run in progress (LOAD/UP/DOWN)
- Done  out  1  one-cycle pulse on normal completion
- Err  out  1  sticky config error; cleared by next accepted Start
- Trips  out  CYC_W  completed round trips in current/last run

Behaviour:
- Reset (RST=0, async): state IDLE; IN, Load, Up, Down, Busy, Done, Err, Trips = 0; prescaler = 0.
- Config (Start_Val, Top, Bottom, Cycles) is latched on the Start cycle. Inputs changing afterwards have no effect.
- FSM states: IDLE, LOAD, UP, DOWN, DONE.
- IDLE:
  - Start=1 and Bottom<=Top: latch config, Trips<=0, Err<=0, go to LOAD.
  - Start=1 and Bottom>Top: Err<=1, stay IDLE.
- LOAD (1 cycle):
  - Load=1, IN=latched Start_Val, prescaler cleared.
  - Next state UP. Counter reflects Start_Val on the first UP cycle.
- Tick: asserted when the prescaler equals PRESCALE-1. The prescaler then wraps to 0; otherwise it increments. It runs in UP/DOWN only.
- UP:
  - Up = tick && Counter<Top && !High (combinational from state and registered inputs).
  - When Counter>=Top, go to DOWN next cycle with no Up pulse. A Start_Val above Top therefore goes straight to DOWN.
- DOWN:
  - Down = tick && Counter>Bottom && !Low.
  - When Counter<=Bottom, Trips<=Trips+1 (wraps modulo 2^CYC_W).
  - If Cycles!=0 and Trips+1==Cycles, go to DONE; else go to UP.
- DONE: Done=1 for exactly one cycle, then IDLE. Trips holds its final value.
- Busy=1 in LOAD, UP and DOWN; 0 in IDLE and DONE.
- Load, Up and Down are mutually exclusive every cycle. Load never coincides with a tick.
- Abort=1 in any non-IDLE state:
  - Next state IDLE, with Up/Down/Load forced 0 in that same cycle.
  - No Done pulse; Trips holds its value.
- Abort and Start in the same IDLE cycle: Abort wins and Start is dropped.
- Top==Bottom: each trip takes one UP cycle and one DOWN cycle with no steps. Trips increments every 2 cycles after LOAD.
- Top=31 / Bottom=0: the !High / !Low gating guarantees the counter never wraps.
- Async reset mid-run: immediate IDLE with all outputs 0. The counter value is left as-is.

Test Plan:
- Reset mid-UP sweep (RST low for 3 cycles) -> Busy/Up/Down/Load drop immediately; state IDLE; Trips=0.
- PRESCALE=1, Start_Val=2, Top=5, Bottom=2, Cycles=2 -> Load at cycle 1. Counter sequence is 2,3,4,5,5,4,3,2,2,3,4,5,5,4,3,2. Trips goes 1 then 2. Done pulses once and Busy falls the same cycle.
- PRESCALE=3, Start_Val=0, Top=2, Bottom=0, Cycles=1 -> Up pulses exactly every 3rd cycle. Counter reaches 2 at cycle ~7, returns to 0. Done pulses once with Trips=1.
- Bottom=9, Top=4, Start=1 -> Err=1, Busy stays 0, no Load. A following valid Start clears Err.
- Cycles=0, Top=31, Bottom=0, Start_Val=30 -> counter never exceeds 31 or goes below 0. High/Low respected and no wrap. Trips increments each trip. Abort after 3 trips -> IDLE next cycle, no Done, Trips=3.
- Start asserted while Busy (mid-DOWN) -> ignored, config unchanged. Start+Abort in same IDLE cycle -> stays IDLE, Busy=0.
